// File: rtl/inst_mem_responder.sv
// Instruction-memory responder for the fetch interface.
// Accepts a program-counter fetch, waits WAIT_CYCLES extra cycles to model
// slow memory, then returns the addressed word with a one-cycle valid pulse.
// Misaligned and out-of-range fetches return NOP_INST with addr_err set.
// A side load port writes program words at any time; a write that lands on
// the in-flight word during the read edge is forwarded into the response.
// Optional feature macro: INST_MEM_LAST_HIT_EN adds a one-entry last-fetch
// register so that a repeated fetch of the same word skips the wait states.
module inst_mem_responder #(
    parameter int          PC_W        = 32,
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] NOP_INST    = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce,
    input  logic [PC_W-1:0]       pc,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    output logic                  addr_err,
    output logic                  busy,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_M1 = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state, state_n;
    logic [3:0]              cnt, cnt_n;
    logic [DEPTH_LOG2-1:0]   req_idx, req_idx_n;
    logic                    req_err, req_err_n;
    logic [31:0]             inst_n;
    logic                    valid_n;
    logic                    err_n;

    logic [DEPTH_LOG2-1:0]   cur_idx;
    logic                    cur_err;
    logic                    accept;
    logic                    do_read;
    logic [DEPTH_LOG2-1:0]   read_idx;
    logic                    read_err;
    logic [31:0]             rd_word;
    logic                    hit;
    logic [31:0]             hit_word;

    logic [31:0]             mem [DEPTH];

    assign cur_idx = pc[DEPTH_LOG2+1:2];
    assign cur_err = (pc[1:0] != 2'b00) || ((pc >> (DEPTH_LOG2 + 2)) != '0);
    assign accept  = rom_ce && !ld_en;
    assign busy    = (state == WAIT);

    // Program-load port: writes land in the array on any edge, in any state.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

`ifdef INST_MEM_LAST_HIT_EN
    logic                  hit_vld;
    logic [DEPTH_LOG2-1:0] hit_idx;
    logic [31:0]           hit_data;

    // Last-fetch entry: refilled on every good read, dropped when its word is rewritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_vld  <= 1'b0;
            hit_idx  <= '0;
            hit_data <= NOP_INST;
        end else if (do_read && !read_err) begin
            hit_vld  <= 1'b1;
            hit_idx  <= read_idx;
            hit_data <= inst_n;
        end else if (ld_en && (ld_addr == hit_idx)) begin
            hit_vld  <= 1'b0;
        end
    end

    // A good fetch whose word matches the live entry can be answered at once.
    always_comb begin
        hit      = hit_vld && (hit_idx == cur_idx) && !cur_err;
        hit_word = hit_data;
    end
`else
    // Without the last-fetch register every fetch takes the full wait.
    always_comb begin
        hit      = 1'b0;
        hit_word = NOP_INST;
    end
`endif

    // Next-state and next-output logic; the array read happens on the edge that enters RESP.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        req_idx_n = req_idx;
        req_err_n = req_err;
        inst_n    = inst;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        do_read   = 1'b0;
        read_idx  = req_idx;
        read_err  = req_err;
        rd_word   = NOP_INST;

        case (state)
            IDLE, RESP: begin
                state_n = IDLE;
                if (accept) begin
                    req_idx_n = cur_idx;
                    req_err_n = cur_err;
                    if (hit) begin
                        state_n = RESP;
                        valid_n = 1'b1;
                        inst_n  = hit_word;
                    end else if (WAIT_CYCLES == 0) begin
                        state_n  = RESP;
                        do_read  = 1'b1;
                        read_idx = cur_idx;
                        read_err = cur_err;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = WAIT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_n = RESP;
                    do_read = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (do_read) begin
            rd_word = (ld_en && (ld_addr == read_idx)) ? ld_data : mem[read_idx];
            valid_n = 1'b1;
            err_n   = read_err;
            inst_n  = read_err ? NOP_INST : rd_word;
        end
    end

    // State and registered outputs; reset aborts any fetch in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_idx    <= '0;
            req_err    <= 1'b0;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            req_idx    <= req_idx_n;
            req_err    <= req_err_n;
            inst       <= inst_n;
            inst_valid <= valid_n;
            addr_err   <= err_n;
        end
    end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Testbench for inst_mem_responder.
// Two instances share clock and reset: one with two wait states, one with none.
// Stimulus pushes the expected response (word, error flag, due cycle) into a
// per-instance queue; a monitor pops and compares whenever inst_valid is seen.
// Honours INST_MEM_LAST_HIT_EN for the expected latency of a repeated fetch.
module tb_inst_mem_responder;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          due;
    } exp_t;

`ifdef INST_MEM_LAST_HIT_EN
    localparam int HIT_LAT = 0;
`else
    localparam int HIT_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        ce2 = 1'b0;
    logic [31:0] pc2 = '0;
    logic [31:0] inst2;
    logic        valid2, err2, busy2;
    logic        lden2 = 1'b0;
    logic [9:0]  ldaddr2 = '0;
    logic [31:0] lddata2 = '0;

    logic        ce0 = 1'b0;
    logic [31:0] pc0 = '0;
    logic [31:0] inst0;
    logic        valid0, err0, busy0;
    logic        lden0 = 1'b0;
    logic [9:0]  ldaddr0 = '0;
    logic [31:0] lddata0 = '0;

    int   cyc = 0;
    int   nChecks = 0;
    int   nPassed = 0;
    exp_t q2[$];
    exp_t q0[$];

    inst_mem_responder #(
        .PC_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(2), .NOP_INST(32'h0000_0000)
    ) dut2 (
        .clk(clk), .rst(rst), .rom_ce(ce2), .pc(pc2),
        .inst(inst2), .inst_valid(valid2), .addr_err(err2), .busy(busy2),
        .ld_en(lden2), .ld_addr(ldaddr2), .ld_data(lddata2)
    );

    inst_mem_responder #(
        .PC_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0), .NOP_INST(32'h0000_0000)
    ) dut0 (
        .clk(clk), .rst(rst), .rom_ce(ce0), .pc(pc0),
        .inst(inst0), .inst_valid(valid0), .addr_err(err0), .busy(busy0),
        .ld_en(lden0), .ld_addr(ldaddr0), .ld_data(lddata0)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used to time-stamp expected responses.
    always @(posedge clk) cyc <= cyc + 1;

    // Safety net so a stuck run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, actual, expected, cyc);
        else
            nPassed++;
    endtask

    // Monitor for the two-wait-state instance.
    always @(negedge clk) begin
        if (valid2 === 1'b1) begin
            if (q2.size() == 0) begin
                checkOutput("dut2 unexpected valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                checkOutput("dut2 inst", inst2, e.inst);
                checkOutput("dut2 addr_err", {31'd0, err2}, {31'd0, e.err});
                checkOutput("dut2 valid cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Monitor for the zero-wait-state instance.
    always @(negedge clk) begin
        if (valid0 === 1'b1) begin
            if (q0.size() == 0) begin
                checkOutput("dut0 unexpected valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                checkOutput("dut0 inst", inst0, e.inst);
                checkOutput("dut0 addr_err", {31'd0, err0}, {31'd0, e.err});
                checkOutput("dut0 valid cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic applyStimulus(input bit which0, input logic [31:0] pcv,
                                 input logic [31:0] expInst, input logic expErr, input int lat);
        @(negedge clk);
        if (which0) begin
            ce0 = 1'b1; pc0 = pcv;
            q0.push_back('{expInst, expErr, cyc + 1 + lat});
        end else begin
            ce2 = 1'b1; pc2 = pcv;
            q2.push_back('{expInst, expErr, cyc + 1 + lat});
        end
    endtask

    task automatic loadWord(input bit which0, input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        if (which0) begin
            lden0 = 1'b1; ldaddr0 = a; lddata0 = d;
        end else begin
            lden2 = 1'b1; ldaddr2 = a; lddata2 = d;
        end
        @(negedge clk);
        lden0 = 1'b0;
        lden2 = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && (q2.size() != 0 || q0.size() != 0); i++) @(negedge clk);
        checkOutput(name, 32'(q2.size() + q0.size()), 32'd0);
    endtask

    task automatic fetch2(input logic [31:0] pcv, input logic [31:0] expInst, input logic expErr, input int lat);
        applyStimulus(1'b0, pcv, expInst, expErr, lat);
        @(negedge clk);
        ce2 = 1'b0;
        drain("dut2 response arrived");
    endtask

    initial begin
        // Reset state of both instances.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset inst2", inst2, 32'h0);
        checkOutput("reset valid2", {31'd0, valid2}, 32'd0);
        checkOutput("reset err2", {31'd0, err2}, 32'd0);
        checkOutput("reset busy2", {31'd0, busy2}, 32'd0);
        checkOutput("reset inst0", inst0, 32'h0);
        checkOutput("reset valid0", {31'd0, valid0}, 32'd0);
        checkOutput("reset busy0", {31'd0, busy0}, 32'd0);

        // Basic fetch with two wait states, watching busy.
        loadWord(1'b0, 10'd3, 32'h2401_0005);
        applyStimulus(1'b0, 32'h0000_000C, 32'h2401_0005, 1'b0, 2);
        @(negedge clk);
        ce2 = 1'b0;
        checkOutput("busy wait1", {31'd0, busy2}, 32'd1);
        @(negedge clk);
        checkOutput("busy wait2", {31'd0, busy2}, 32'd1);
        @(negedge clk);
        checkOutput("busy resp", {31'd0, busy2}, 32'd0);
        @(negedge clk);
        checkOutput("hold valid2", {31'd0, valid2}, 32'd0);
        checkOutput("hold inst2", inst2, 32'h2401_0005);
        checkOutput("hold err2", {31'd0, err2}, 32'd0);
        drain("dut2 first fetch");

        // Misaligned and out-of-range fetches.
        fetch2(32'h0000_0006, 32'h0, 1'b1, 2);
        fetch2(32'h0000_1000, 32'h0, 1'b1, 2);

        // Write-through forwarding on the read edge.
        loadWord(1'b0, 10'd4, 32'h1111_1111);
        applyStimulus(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 2);
        @(negedge clk);
        ce2 = 1'b0;
        @(negedge clk);
        lden2 = 1'b1; ldaddr2 = 10'd4; lddata2 = 32'hDEAD_BEEF;
        @(negedge clk);
        lden2 = 1'b0;
        drain("dut2 forwarded fetch");

        // Write on an earlier wait edge is simply visible at the read.
        loadWord(1'b0, 10'd5, 32'h5555_5555);
        applyStimulus(1'b0, 32'h0000_0014, 32'hCAFE_F00D, 1'b0, 2);
        @(negedge clk);
        ce2 = 1'b0;
        lden2 = 1'b1; ldaddr2 = 10'd5; lddata2 = 32'hCAFE_F00D;
        @(negedge clk);
        lden2 = 1'b0;
        drain("dut2 early-write fetch");

        // Repeated fetch, then rewrite of that word.
        loadWord(1'b0, 10'd8, 32'h0808_0808);
        fetch2(32'h0000_0020, 32'h0808_0808, 1'b0, 2);
        fetch2(32'h0000_0020, 32'h0808_0808, 1'b0, HIT_LAT);
        loadWord(1'b0, 10'd8, 32'h8888_0000);
        fetch2(32'h0000_0020, 32'h8888_0000, 1'b0, 2);

        // Back-to-back fetches with no wait states.
        loadWord(1'b1, 10'd0, 32'h1000_0000);
        loadWord(1'b1, 10'd1, 32'h1000_0001);
        loadWord(1'b1, 10'd2, 32'h1000_0002);
        applyStimulus(1'b1, 32'h0000_0000, 32'h1000_0000, 1'b0, 0);
        applyStimulus(1'b1, 32'h0000_0004, 32'h1000_0001, 1'b0, 0);
        applyStimulus(1'b1, 32'h0000_0008, 32'h1000_0002, 1'b0, 0);
        applyStimulus(1'b1, 32'h0000_1000, 32'h0, 1'b1, 0);
        @(negedge clk);
        ce0 = 1'b0;
        drain("dut0 responses arrived");

        // Reset in the middle of a wait aborts the fetch.
        @(negedge clk);
        ce2 = 1'b1; pc2 = 32'h0000_000C;
        @(negedge clk);
        ce2 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort inst2", inst2, 32'h0);
        checkOutput("abort valid2", {31'd0, valid2}, 32'd0);
        checkOutput("abort busy2", {31'd0, busy2}, 32'd0);
        checkOutput("abort err2", {31'd0, err2}, 32'd0);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
